iir_cascade_mc: RTL and testbench

Time-multiplexed, multi-channel cascade of second-order IIR (biquad) sections. One shared biquad datapath evaluates one stage per clock. Each channel keeps its own per-stage delay state, so up to NUM_CH independent audio/sensor streams are filtered by the same coefficient set. The block sits between a sample source with valid/ready handshake and a downstream consumer that takes one-cycle output pulses.

---
 rtl/iir_pkg.sv | 28 ++
 rtl/iir_biquad_dp.sv | 65 ++++++
 rtl/iir_cascade_mc.sv | 206 ++++++++++++++++++++
 tb/tb_iir_cascade_mc.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared FSM type and sizing/indexing helpers for the time-multiplexed biquad cascade.
package iir_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } iir_state_t;

    // Coefficient order inside one stage slice, b0 in the least significant position.
    localparam int C_B0 = 0;
    localparam int C_B1 = 1;
    localparam int C_B2 = 2;
    localparam int C_A1 = 3;
    localparam int C_A2 = 4;

    function automatic int chw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w_f(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

    function automatic int coef_lsb_f(input int stage, input int k, input int cw);
        return (stage * 5 + k) * cw;
    endfunction

endpackage

// File: rtl/iir_biquad_dp.sv
// Combinational biquad evaluation: full-precision MAC, round-half-up, reduce to DWIDTH.
// Reduction saturates when IIR_SAT_EN is defined, otherwise wraps (two's complement).
module iir_biquad_dp
    import iir_pkg::*;
#(
    parameter int DWIDTH = 24,
    parameter int CWIDTH = 24,
    parameter int CFRAC  = 22
) (
    input  logic signed [CWIDTH-1:0] i_b0,
    input  logic signed [CWIDTH-1:0] i_b1,
    input  logic signed [CWIDTH-1:0] i_b2,
    input  logic signed [CWIDTH-1:0] i_a1,
    input  logic signed [CWIDTH-1:0] i_a2,
    input  logic signed [DWIDTH-1:0] i_x0,
    input  logic signed [DWIDTH-1:0] i_x1,
    input  logic signed [DWIDTH-1:0] i_x2,
    input  logic signed [DWIDTH-1:0] i_y1,
    input  logic signed [DWIDTH-1:0] i_y2,
    output logic signed [DWIDTH-1:0] o_y0
);

    localparam int AW = acc_w_f(DWIDTH, CWIDTH);
    localparam logic signed [AW-1:0] RND = AW'(1) <<< (CFRAC - 1);

    function automatic logic signed [AW-1:0] mul_f(input logic signed [CWIDTH-1:0] c,
                                                   input logic signed [DWIDTH-1:0] x);
        logic signed [AW-1:0] ce;
        logic signed [AW-1:0] xe;
        ce = {{(AW - CWIDTH){c[CWIDTH-1]}}, c};
        xe = {{(AW - DWIDTH){x[DWIDTH-1]}}, x};
        return ce * xe;
    endfunction

    function automatic logic signed [AW-1:0] round_f(input logic signed [AW-1:0] acc);
        return (acc + RND) >>> CFRAC;
    endfunction

`ifdef IIR_SAT_EN
    localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (DWIDTH - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SMIN = -(AW'(1) <<< (DWIDTH - 1));

    function automatic logic signed [DWIDTH-1:0] reduce_f(input logic signed [AW-1:0] v);
        if (v > SMAX) begin
            return SMAX[DWIDTH-1:0];
        end else if (v < SMIN) begin
            return SMIN[DWIDTH-1:0];
        end
        return v[DWIDTH-1:0];
    endfunction
`else
    function automatic logic signed [DWIDTH-1:0] reduce_f(input logic signed [AW-1:0] v);
        return v[DWIDTH-1:0];
    endfunction
`endif

    logic signed [AW-1:0] w_acc;
    logic signed [AW-1:0] w_shf;

    assign w_acc = mul_f(i_b0, i_x0) + mul_f(i_b1, i_x1) + mul_f(i_b2, i_x2)
                 - mul_f(i_a1, i_y1) - mul_f(i_a2, i_y2);
    assign w_shf = round_f(w_acc);
    assign o_y0  = reduce_f(w_shf);

endmodule

// File: rtl/iir_cascade_mc.sv
// Multi-channel biquad cascade: one shared datapath, one stage per clock, per-channel delay state.
// Define IIR_SAT_EN to saturate stage outputs instead of wrapping them.
module iir_cascade_mc
    import iir_pkg::*;
#(
    parameter  int NUM_STAGE = 10,
    parameter  int NUM_CH    = 2,
    parameter  int DWIDTH    = 24,
    parameter  int CWIDTH    = 24,
    parameter  int CFRAC     = 22,
    localparam int CHW       = chw_f(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          block_en,
    input  logic [NUM_STAGE*5*CWIDTH-1:0] coefs,
    input  logic [NUM_STAGE-1:0]          stage_byp,
    input  logic                          din_vld,
    output logic                          din_rdy,
    input  logic [CHW-1:0]                din_ch,
    input  logic signed [DWIDTH-1:0]      din,
    output logic                          dout_vld,
    output logic [CHW-1:0]                dout_ch,
    output logic signed [DWIDTH-1:0]      dout
);

    localparam int              CNTW   = chw_f(NUM_STAGE);
    localparam logic [CNTW-1:0] LAST   = CNTW'(NUM_STAGE - 1);
    localparam logic [CHW:0]    CH_LIM = (CHW + 1)'(NUM_CH);

    iir_state_t               r_state;
    iir_state_t               w_state_nxt;
    logic [CNTW-1:0]          r_cnt;
    logic signed [DWIDTH-1:0] r_xcur;
    logic [CHW-1:0]           r_ch;

    logic w_accept;
    logic w_ch_ok;
    logic w_start;
    logic w_run;
    logic w_last;
    logic w_byp;
    logic w_commit;

    logic signed [CWIDTH-1:0] w_b0;
    logic signed [CWIDTH-1:0] w_b1;
    logic signed [CWIDTH-1:0] w_b2;
    logic signed [CWIDTH-1:0] w_a1;
    logic signed [CWIDTH-1:0] w_a2;
    logic signed [DWIDTH-1:0] w_x1;
    logic signed [DWIDTH-1:0] w_x2;
    logic signed [DWIDTH-1:0] w_y1;
    logic signed [DWIDTH-1:0] w_y2;
    logic signed [DWIDTH-1:0] w_y0;
    logic signed [DWIDTH-1:0] w_sout;

    logic signed [DWIDTH-1:0] w_x1_a [NUM_CH][NUM_STAGE];
    logic signed [DWIDTH-1:0] w_x2_a [NUM_CH][NUM_STAGE];
    logic signed [DWIDTH-1:0] w_y1_a [NUM_CH][NUM_STAGE];
    logic signed [DWIDTH-1:0] w_y2_a [NUM_CH][NUM_STAGE];

    // Out-of-range channels complete the handshake but never start a RUN phase.
    assign w_ch_ok  = ({1'b0, din_ch} < CH_LIM);
    assign w_accept = din_vld & din_rdy;
    assign w_start  = w_accept & w_ch_ok;
    assign w_run    = (r_state == RUN);
    assign w_last   = w_run & (r_cnt == LAST);
    assign w_byp    = stage_byp[r_cnt];
    assign w_commit = w_run & ~w_byp;

    assign w_b0 = coefs[coef_lsb_f(int'(r_cnt), C_B0, CWIDTH) +: CWIDTH];
    assign w_b1 = coefs[coef_lsb_f(int'(r_cnt), C_B1, CWIDTH) +: CWIDTH];
    assign w_b2 = coefs[coef_lsb_f(int'(r_cnt), C_B2, CWIDTH) +: CWIDTH];
    assign w_a1 = coefs[coef_lsb_f(int'(r_cnt), C_A1, CWIDTH) +: CWIDTH];
    assign w_a2 = coefs[coef_lsb_f(int'(r_cnt), C_A2, CWIDTH) +: CWIDTH];

    assign w_x1 = w_x1_a[r_ch][r_cnt];
    assign w_x2 = w_x2_a[r_ch][r_cnt];
    assign w_y1 = w_y1_a[r_ch][r_cnt];
    assign w_y2 = w_y2_a[r_ch][r_cnt];

    iir_biquad_dp #(
        .DWIDTH (DWIDTH),
        .CWIDTH (CWIDTH),
        .CFRAC  (CFRAC)
    ) u_dp (
        .i_b0 (w_b0),
        .i_b1 (w_b1),
        .i_b2 (w_b2),
        .i_a1 (w_a1),
        .i_a2 (w_a2),
        .i_x0 (r_xcur),
        .i_x1 (w_x1),
        .i_x2 (w_x2),
        .i_y1 (w_y1),
        .i_y2 (w_y2),
        .o_y0 (w_y0)
    );

    // A bypassed stage passes its input through untouched.
    assign w_sout = w_byp ? r_xcur : w_y0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!block_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) w_state_nxt = RUN;
                RUN:     if (r_cnt == LAST) w_state_nxt = w_start ? RUN : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        din_rdy = 1'b0;
        if (rstn && block_en) begin
            case (r_state)
                IDLE:    din_rdy = 1'b1;
                RUN:     din_rdy = (r_cnt == LAST);
                default: din_rdy = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!block_en || w_start) begin
            r_cnt <= '0;
        end else if (w_run && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!block_en) begin
            r_xcur <= '0;
            r_ch   <= '0;
        end else if (w_start) begin
            r_xcur <= din;
            r_ch   <= din_ch;
        end else if (w_commit) begin
            r_xcur <= w_y0;
        end
    end

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
        for (genvar gs = 0; gs < NUM_STAGE; gs++) begin : g_st
            logic signed [DWIDTH-1:0] r_x1;
            logic signed [DWIDTH-1:0] r_x2;
            logic signed [DWIDTH-1:0] r_y1;
            logic signed [DWIDTH-1:0] r_y2;
            logic                     w_upd;

            assign w_upd = w_commit && (r_ch == CHW'(gc)) && (r_cnt == CNTW'(gs));

            always_ff @(posedge clk) begin
                if (!block_en) begin
                    r_x1 <= '0;
                    r_x2 <= '0;
                    r_y1 <= '0;
                    r_y2 <= '0;
                end else if (w_upd) begin
                    r_x2 <= r_x1;
                    r_x1 <= r_xcur;
                    r_y2 <= r_y1;
                    r_y1 <= w_y0;
                end
            end

            assign w_x1_a[gc][gs] = r_x1;
            assign w_x2_a[gc][gs] = r_x2;
            assign w_y1_a[gc][gs] = r_y1;
            assign w_y2_a[gc][gs] = r_y2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_vld <= 1'b0;
            dout_ch  <= '0;
            dout     <= '0;
        end else if (!block_en) begin
            dout_vld <= 1'b0;
            dout_ch  <= '0;
            dout     <= '0;
        end else begin
            dout_vld <= w_last;
            if (w_last) begin
                dout    <= w_sout;
                dout_ch <= r_ch;
            end
        end
    end

endmodule

// File: tb/tb_iir_cascade_mc.sv
// Directed bench for iir_cascade_mc with two stages and two channels.
`timescale 1ns/1ps
module tb_iir_cascade_mc;

    localparam int NS = 2;
    localparam int NC = 2;
    localparam int DW = 24;
    localparam int CW = 24;
    localparam int CF = 22;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   block_en;
    logic [NS*5*CW-1:0]     coefs;
    logic [NS-1:0]          stage_byp;
    logic                   din_vld;
    logic                   din_rdy;
    logic [0:0]             din_ch;
    logic signed [DW-1:0]   din;
    logic                   dout_vld;
    logic [0:0]             dout_ch;
    logic signed [DW-1:0]   dout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iir_cascade_mc #(
        .NUM_STAGE (NS),
        .NUM_CH    (NC),
        .DWIDTH    (DW),
        .CWIDTH    (CW),
        .CFRAC     (CF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .block_en  (block_en),
        .coefs     (coefs),
        .stage_byp (stage_byp),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .din_ch    (din_ch),
        .din       (din),
        .dout_vld  (dout_vld),
        .dout_ch   (dout_ch),
        .dout      (dout)
    );

    task automatic set_stage(input int k, input int b0, input int b1, input int b2,
                             input int a1, input int a2);
        coefs[(k*5+0)*CW +: CW] = CW'(b0);
        coefs[(k*5+1)*CW +: CW] = CW'(b1);
        coefs[(k*5+2)*CW +: CW] = CW'(b2);
        coefs[(k*5+3)*CW +: CW] = CW'(a1);
        coefs[(k*5+4)*CW +: CW] = CW'(a2);
    endtask

    task automatic clear_state();
        block_en = 1'b0;
        @(posedge clk); #1;
        block_en = 1'b1;
    endtask

    task automatic send(input int ch, input int val);
        int t = 0;
        while (!din_rdy && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (din_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL send_rdy got %0b want 1", din_rdy);
        end
        din_vld = 1'b1;
        din_ch  = 1'(ch);
        din     = DW'(val);
        @(posedge clk); #1;
        din_vld = 1'b0;
    endtask

    task automatic get_out(output int v, output int c, output int lat, output bit ok);
        v = 0; c = 0; lat = 0; ok = 1'b0;
        while (!ok && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (dout_vld) begin
                ok = 1'b1;
                v  = int'(dout);
                c  = int'(dout_ch);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; block_en = 1'b1; din_vld = 1'b0; din_ch = '0; din = '0;
        coefs = '0; stage_byp = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 4;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %0b want 0", dout_vld); end
        if (dout !== '0)       begin n_fail++; $display("FAIL rst_dout got %0d want 0", dout); end
        if (dout_ch !== '0)    begin n_fail++; $display("FAIL rst_ch got %0d want 0", dout_ch); end
        if (din_rdy !== 1'b0)  begin n_fail++; $display("FAIL rst_rdy got %0b want 0", din_rdy); end
        rstn = 1'b1; block_en = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL en_low_rdy got %0b want 0", din_rdy); end
        block_en = 1'b1;
        #1;
        n_cmp++;
        if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL en_high_rdy got %0b want 1", din_rdy); end
    endtask

    task automatic test_identity();
        int v, c, lat;
        bit ok;
        set_stage(0, 4194304, 0, 0, 0, 0);
        set_stage(1, 4194304, 0, 0, 0, 0);
        send(0, 1000);
        get_out(v, c, lat, ok);
        n_cmp += 4;
        if (!ok)        begin n_fail++; $display("FAIL id_timeout got none want pulse"); end
        if (v != 1000)  begin n_fail++; $display("FAIL id_dout got %0d want 1000", v); end
        if (c != 0)     begin n_fail++; $display("FAIL id_ch got %0d want 0", c); end
        if (lat != 2)   begin n_fail++; $display("FAIL id_latency got %0d want 2", lat); end
        @(posedge clk); #1;
        n_cmp += 2;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL id_pulse_width got %0b want 0", dout_vld); end
        if (int'(dout) != 1000) begin n_fail++; $display("FAIL id_hold got %0d want 1000", dout); end
    endtask

    task automatic test_impulse();
        int ins[3]  = '{1000, 0, 0};
        int want[3] = '{1000, 500, 250};
        int v, c, lat;
        bit ok;
        clear_state();
        set_stage(0, 4194304, 0, 0, -2097152, 0);
        set_stage(1, 4194304, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send(0, ins[i]);
            get_out(v, c, lat, ok);
            n_cmp++;
            if (!ok || v != want[i]) begin
                n_fail++;
                $display("FAIL impulse[%0d] got %0d (vld %0b) want %0d", i, v, ok, want[i]);
            end
        end
    endtask

    task automatic test_isolation();
        int chs[3]  = '{0, 1, 0};
        int ins[3]  = '{1000, 0, 0};
        int want[3] = '{1000, 0, 500};
        int v, c, lat;
        bit ok;
        clear_state();
        for (int i = 0; i < 3; i++) begin
            send(chs[i], ins[i]);
            get_out(v, c, lat, ok);
            n_cmp += 2;
            if (!ok || v != want[i]) begin
                n_fail++;
                $display("FAIL iso_dout[%0d] got %0d (vld %0b) want %0d", i, v, ok, want[i]);
            end
            if (c != chs[i]) begin
                n_fail++;
                $display("FAIL iso_ch[%0d] got %0d want %0d", i, c, chs[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int want[2];
        int v, c, lat;
        bit ok;
`ifdef IIR_SAT_EN
        want[0] = 8388607;
        want[1] = 8388607;
`else
        want[0] = -4194305;
        want[1] = 8388605;
`endif
        clear_state();
        set_stage(0, 6291456, 6291456, 0, 0, 0);
        set_stage(1, 4194304, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            send(0, 8388607);
            get_out(v, c, lat, ok);
            n_cmp++;
            if (!ok || v != want[i]) begin
                n_fail++;
                $display("FAIL sat[%0d] got %0d (vld %0b) want %0d", i, v, ok, want[i]);
            end
        end
    endtask

    task automatic test_bypass_throughput();
        int vals[3] = '{5, -7, 9};
        int acc_cyc[3] = '{0, 0, 0};
        int outv[3] = '{0, 0, 0};
        int idx  = 0;
        int nout = 0;
        bit a;
        stage_byp = 2'b11;
        din_ch  = 1'b0;
        din     = DW'(vals[0]);
        din_vld = 1'b1;
        for (int c = 0; c < 30 && nout < 3; c++) begin
            a = din_rdy && din_vld;
            @(posedge clk); #1;
            if (a) begin
                acc_cyc[idx] = c;
                idx++;
                if (idx < 3) din = DW'(vals[idx]);
                else         din_vld = 1'b0;
            end
            if (dout_vld) begin
                outv[nout] = int'(dout);
                nout++;
            end
        end
        din_vld = 1'b0;
        n_cmp += 3;
        if (nout != 3) begin n_fail++; $display("FAIL byp_count got %0d want 3", nout); end
        if (acc_cyc[1] - acc_cyc[0] != 2) begin
            n_fail++; $display("FAIL byp_rate01 got %0d want 2", acc_cyc[1] - acc_cyc[0]);
        end
        if (acc_cyc[2] - acc_cyc[1] != 2) begin
            n_fail++; $display("FAIL byp_rate12 got %0d want 2", acc_cyc[2] - acc_cyc[1]);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (outv[i] != vals[i]) begin
                n_fail++;
                $display("FAIL byp_dout[%0d] got %0d want %0d", i, outv[i], vals[i]);
            end
        end
        stage_byp = 2'b00;
    endtask

    task automatic test_abort();
        int ins[3]  = '{1000, 0, 0};
        int want[3] = '{1000, 500, 250};
        int v, c, lat, pulses;
        bit ok;
        clear_state();
        set_stage(0, 4194304, 0, 0, -2097152, 0);
        set_stage(1, 4194304, 0, 0, 0, 0);
        send(0, 1000);
        get_out(v, c, lat, ok);
        send(1, 400);
        get_out(v, c, lat, ok);
        n_cmp++;
        if (!ok || v != 400 || c != 1) begin
            n_fail++; $display("FAIL abort_pre got %0d ch %0d want 400 ch 1", v, c);
        end
        send(0, 777);
        block_en = 1'b0;
        #1;
        n_cmp++;
        if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_rdy got %0b want 0", din_rdy); end
        @(posedge clk); #1;
        block_en = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (dout_vld) pulses++;
        end
        n_cmp += 3;
        if (pulses != 0)  begin n_fail++; $display("FAIL abort_vld got %0d pulses want 0", pulses); end
        if (dout !== '0)  begin n_fail++; $display("FAIL abort_dout got %0d want 0", dout); end
        if (dout_ch !== '0) begin n_fail++; $display("FAIL abort_ch got %0d want 0", dout_ch); end
        for (int i = 0; i < 3; i++) begin
            send(0, ins[i]);
            get_out(v, c, lat, ok);
            n_cmp++;
            if (!ok || v != want[i]) begin
                n_fail++;
                $display("FAIL abort_impulse[%0d] got %0d (vld %0b) want %0d", i, v, ok, want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_impulse();
        test_isolation();
        test_saturation();
        test_bypass_throughput();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
